// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder buffer: captures bit-reversed FFT frames and re-emits them
// in natural order. One bank fills while the other drains, so frames can stream back to back.
module fft_reorder_buffer #(
    parameter int LOG_N = 6,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int N = 1 << LOG_N;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = a[LOG_N-1-i];
        end
        return r;
    endfunction

    // Bank select is the top address bit.
    logic [2*WIDTH-1:0] r_mem [2*N];

    logic [LOG_N-1:0]   r_wr_cnt;
    logic               r_wr_bank;
    logic               r_req;
    logic               r_req_bank;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LOG_N-1:0]   r_rd_cnt;
    logic [LOG_N-1:0]   w_rd_cnt_nxt;
    logic               r_rd_bank;
    logic               w_rd_bank_nxt;
    logic               w_consume;
    logic               w_frame_done;
    logic               w_rd_last;
    logic [2*WIDTH-1:0] w_rd_data;

    assign w_frame_done = di_en && (r_wr_cnt == '1);
    assign w_rd_last    = (r_rd_cnt == '1);
    assign w_rd_data    = r_mem[{r_rd_bank, r_rd_cnt}];

    always_ff @(posedge clock) begin
        if (reset_n && di_en) begin
            r_mem[{r_wr_bank, bitrev(r_wr_cnt)}] <= {di_re, di_im};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (di_en) begin
            r_wr_cnt <= r_wr_cnt + LOG_N'(1);
            if (w_frame_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // A fill takes at least N cycles, so a new request never collides with consumption of the old one.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_req      <= 1'b0;
            r_req_bank <= 1'b0;
        end else if (w_frame_done) begin
            r_req      <= 1'b1;
            r_req_bank <= r_wr_bank;
        end else if (w_consume) begin
            r_req <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_cnt  <= w_rd_cnt_nxt;
            r_rd_bank <= w_rd_bank_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_cnt_nxt  = r_rd_cnt;
        w_rd_bank_nxt = r_rd_bank;
        w_consume     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_req) begin
                    w_state_nxt   = ST_DRAIN;
                    w_rd_cnt_nxt  = '0;
                    w_rd_bank_nxt = r_req_bank;
                    w_consume     = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_rd_cnt_nxt = r_rd_cnt + LOG_N'(1);
                if (w_rd_last) begin
                    // Pending frame restarts the drain immediately so output has no bubble.
                    if (r_req) begin
                        w_rd_cnt_nxt  = '0;
                        w_rd_bank_nxt = r_req_bank;
                        w_consume     = 1'b1;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                        w_rd_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_rd_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            do_en <= 1'b0;
            do_re <= '0;
            do_im <= '0;
        end else if (r_state == ST_DRAIN) begin
            do_en <= 1'b1;
            do_re <= w_rd_data[2*WIDTH-1:WIDTH];
            do_im <= w_rd_data[WIDTH-1:0];
        end else begin
            do_en <= 1'b0;
            do_re <= '0;
            do_im <= '0;
        end
    end

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Bench for fft_reorder_buffer: an N=8 instance for the directed cases and a default
// N=64 instance for random frames; expected samples and their cycles are queued as frames are sent.
module tb_fft_reorder_buffer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clock = ~clock;

    logic        di_en3, di_en6, do_en3, do_en6;
    logic [15:0] di_re3, di_im3, do_re3, do_im3;
    logic [15:0] di_re6, di_im6, do_re6, do_im6;

    fft_reorder_buffer #(.LOG_N(3), .WIDTH(16)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .di_en(di_en3), .di_re(di_re3), .di_im(di_im3),
        .do_en(do_en3), .do_re(do_re3), .do_im(do_im3)
    );

    fft_reorder_buffer dut6 (
        .clock(clock), .reset_n(reset_n),
        .di_en(di_en6), .di_re(di_re6), .di_im(di_im6),
        .do_en(do_en6), .do_re(do_re6), .do_im(do_im6)
    );

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          mon_on = 1'b0;
    logic [31:0] exp3_q[$];
    logic [31:0] exp6_q[$];
    int          cyc3_q[$];
    int          cyc6_q[$];
    logic [31:0] e3, e6;
    int          c3, c6;
    logic [15:0] fr_re[64];
    logic [15:0] fr_im[64];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    endtask

    function automatic int bitrev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // which=0 drives the N=8 instance, which=1 the N=64 one; the other gets junk with valid low.
    task automatic drv(input int which, input logic en, input logic [15:0] re, input logic [15:0] im);
        di_en3 = (which == 0) ? en : 1'b0;
        di_re3 = (which == 0 && en) ? re : 16'($urandom);
        di_im3 = (which == 0 && en) ? im : 16'($urandom);
        di_en6 = (which == 1) ? en : 1'b0;
        di_re6 = (which == 1 && en) ? re : 16'($urandom);
        di_im6 = (which == 1 && en) ? im : 16'($urandom);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic send_frame3(input int base, input bit gapped);
        int v;
        int last;
        for (int k = 0; k < 8; k++) begin
            if (gapped && k > 0) idle(1);
            v = base + bitrev(k, 3);
            drv(0, 1'b1, 16'(v), 16'(10 * v));
        end
        last = cyc;
        for (int j = 0; j < 8; j++) begin
            exp3_q.push_back({16'(base + j), 16'(10 * (base + j))});
            cyc3_q.push_back(last + 2 + j);
        end
    endtask

    task automatic send_frame6();
        int last;
        for (int k = 0; k < 64; k++) begin
            fr_re[k] = 16'($urandom_range(0, 65535));
            fr_im[k] = 16'($urandom_range(0, 65535));
            drv(1, 1'b1, fr_re[k], fr_im[k]);
        end
        last = cyc;
        for (int j = 0; j < 64; j++) begin
            exp6_q.push_back({fr_re[bitrev(j, 6)], fr_im[bitrev(j, 6)]});
            cyc6_q.push_back(last + 2 + j);
        end
    endtask

    // Valid is held high through the reset edge; it must be ignored.
    task automatic do_reset();
        reset_n = 1'b0;
        di_en3  = 1'b1;
        di_re3  = 16'hdead;
        di_im3  = 16'hbeef;
        di_en6  = 1'b1;
        di_re6  = 16'hdead;
        di_im6  = 16'hbeef;
        @(posedge clock);
        #1;
        exp3_q.delete();
        cyc3_q.delete();
        exp6_q.delete();
        cyc6_q.delete();
        check("rst_en3", 32'(do_en3), 32'd0);
        check("rst_re3", 32'(do_re3), 32'd0);
        check("rst_im3", 32'(do_im3), 32'd0);
        check("rst_en6", 32'(do_en6), 32'd0);
        reset_n = 1'b1;
        di_en3  = 1'b0;
        di_en6  = 1'b0;
    endtask

    always @(negedge clock) begin
        if (mon_on) begin
            if (do_en3 === 1'b1) begin
                if (exp3_q.size() == 0) begin
                    check("extra3", 32'(do_en3), 32'd0);
                end else begin
                    e3 = exp3_q.pop_front();
                    c3 = cyc3_q.pop_front();
                    check("re3", 32'(do_re3), 32'(e3[31:16]));
                    check("im3", 32'(do_im3), 32'(e3[15:0]));
                    check("cyc3", 32'(cyc), 32'(c3));
                end
            end else begin
                check("en3", 32'(do_en3), 32'd0);
                check("idle3", {do_re3, do_im3}, 32'd0);
            end
        end
    end

    always @(negedge clock) begin
        if (mon_on) begin
            if (do_en6 === 1'b1) begin
                if (exp6_q.size() == 0) begin
                    check("extra6", 32'(do_en6), 32'd0);
                end else begin
                    e6 = exp6_q.pop_front();
                    c6 = cyc6_q.pop_front();
                    check("data6", {do_re6, do_im6}, e6);
                    check("cyc6", 32'(cyc), 32'(c6));
                end
            end else begin
                check("en6", 32'(do_en6), 32'd0);
                check("idle6", {do_re6, do_im6}, 32'd0);
            end
        end
    end

    initial begin
        di_en3 = 1'b0; di_re3 = '0; di_im3 = '0;
        di_en6 = 1'b0; di_re6 = '0; di_im6 = '0;
        repeat (2) @(posedge clock);
        #1;
        do_reset();
        mon_on = 1'b1;
        idle(3);

        // Single frame, then four back-to-back frames.
        send_frame3(0, 1'b0);
        idle(12);
        for (int f = 0; f < 4; f++) send_frame3(8 * f, 1'b0);
        idle(12);

        // Alternating valid.
        send_frame3(0, 1'b1);
        idle(12);

        // Reset after five samples discards the partial frame.
        for (int k = 0; k < 5; k++) drv(0, 1'b1, 16'd99, 16'd99);
        do_reset();
        send_frame3(40, 1'b0);
        idle(12);

        // Reset when the fourth output sample is due.
        send_frame3(16, 1'b0);
        idle(4);
        do_reset();
        idle(3);
        send_frame3(24, 1'b0);
        idle(12);

        for (int f = 0; f < 3; f++) send_frame6();
        idle(80);

        check("left3", 32'(exp3_q.size()), 32'd0);
        check("left6", 32'(exp6_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
